// File: rtl/bit_clmul_iter_pkg.sv
// Shared types and constants for the iterative carry-less multiplier.
package bit_clmul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot {clmulr, clmulh, clmul_}
  typedef logic [2:0] bit_clmul_op;

  localparam int OP_CLMUL  = 0;
  localparam int OP_CLMULH = 1;
  localparam int OP_CLMULR = 2;

endpackage

// File: rtl/bit_clmul_step.sv
// Combinational step: XORs STEP shifted copies of the multiplicand into the accumulator.
module bit_clmul_step
  import bit_clmul_iter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  parameter int CW   = 6
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   rdata1,
  input  logic [STEP-1:0]   bits,
  input  logic [CW-1:0]     base,
  output logic [2*XLEN-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < STEP; j++) begin
      if (bits[j]) begin
        acc_next = acc_next ^ ({{XLEN{1'b0}}, rdata1} << (int'(base) + j));
      end
    end
  end

endmodule

// File: rtl/bit_clmul_iter.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr), STEP multiplier bits per cycle.
module bit_clmul_iter
  import bit_clmul_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEP  = 1,
  parameter int EARLY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  bit_clmul_op       op,
  input  logic [XLEN-1:0]   rdata1,
  input  logic [XLEN-1:0]   rdata2,
  input  logic              clear,
  output logic [XLEN-1:0]   result,
  output logic              ready,
  output logic              busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef struct packed {
    logic            enable;
    bit_clmul_op     op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            clear;
  } bit_clmul_iter_in_type;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            ready;
    logic            busy;
  } bit_clmul_iter_out_type;

  typedef struct packed {
    state_t            state;
    logic [CW-1:0]     counter;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    bit_clmul_op       op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result;
    logic              ready;
  } bit_clmul_iter_reg_type;

  localparam bit_clmul_iter_reg_type init_bit_clmul_iter_reg = '{
    state:   IDLE,
    counter: '0,
    rdata1:  '0,
    rdata2:  '0,
    op:      '0,
    acc:     '0,
    result:  '0,
    ready:   1'b0
  };

  // Priority clmul_ > clmulh > clmulr when several op bits are set.
  function automatic logic [XLEN-1:0] select_slice(input logic [2*XLEN-1:0] p,
                                                   input bit_clmul_op o);
    if (o[OP_CLMUL])       return p[XLEN-1:0];
    else if (o[OP_CLMULH]) return p[2*XLEN-1:XLEN];
    else                   return p[2*XLEN-2:XLEN-1];
  endfunction

  bit_clmul_iter_in_type  d;
  bit_clmul_iter_out_type o;
  bit_clmul_iter_reg_type r, rin;

  logic [STEP-1:0]   bits;
  logic [2*XLEN-1:0] acc_next;

  assign d = '{enable: enable, op: op, rdata1: rdata1, rdata2: rdata2, clear: clear};

  assign bits = STEP'(r.rdata2 >> r.counter);

  bit_clmul_step #(
    .XLEN (XLEN),
    .STEP (STEP),
    .CW   (CW)
  ) u_step (
    .acc      (r.acc),
    .rdata1   (r.rdata1),
    .bits     (bits),
    .base     (r.counter),
    .acc_next (acc_next)
  );

  always_comb begin
    bit_clmul_iter_reg_type v;
    v       = r;
    v.ready = 1'b0;
    case (r.state)
      IDLE: begin
        if (d.enable && (|d.op)) begin
          v.rdata1  = d.rdata1;
          v.rdata2  = d.rdata2;
          v.op      = d.op;
          v.counter = '0;
          v.acc     = '0;
          v.state   = BUSY;
        end
      end
      BUSY: begin
        v.acc     = acc_next;
        v.counter = r.counter + CW'(STEP);
        // Early exit once no set multiplier bits remain above the processed window.
        if ((v.counter == CW'(XLEN)) ||
            ((EARLY != 0) && ((r.rdata2 >> v.counter) == '0))) begin
          v.state = DONE;
        end
      end
      DONE: begin
        v.result = select_slice(r.acc, r.op);
        v.ready  = 1'b1;
        v.state  = IDLE;
      end
      default: v.state = IDLE;
    endcase
    if (d.clear) begin
      v.state  = IDLE;
      v.acc    = '0;
      v.ready  = 1'b0;
      v.result = r.result;
    end
    rin = v;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r <= init_bit_clmul_iter_reg;
    else        r <= rin;
  end

  assign o = '{result: r.result,
               ready:  r.ready,
               busy:   (r.state == BUSY) || (r.state == DONE)};

  assign result = o.result;
  assign ready  = o.ready;
  assign busy   = o.busy;

endmodule
